// File: rtl/label_vote_filter.sv
// rtl/label_vote_filter.sv - sliding-window majority vote over per-inference A/V labels
module label_vote_filter #(
    parameter int CLASSES        = 2,
    parameter int LABEL_WIDTH    = 1,
    parameter int DISTANCE_WIDTH = 11,
    parameter int WINDOW         = 5,
    parameter int DIST_THRESHOLD = 600,
    parameter int VOTE_WIDTH     = $clog2(WINDOW + 1)
) (
    input  logic                      Clk_CI,
    input  logic                      Reset_RI,
    input  logic                      ValidIn_SI,
    output logic                      ReadyOut_SO,
    input  logic [LABEL_WIDTH-1:0]    LabelIn_A_DI,
    input  logic [LABEL_WIDTH-1:0]    LabelIn_V_DI,
    input  logic [DISTANCE_WIDTH-1:0] DistanceIn_A_DI,
    input  logic [DISTANCE_WIDTH-1:0] DistanceIn_V_DI,
    input  logic                      Clear_SI,
    input  logic                      ReadyIn_SI,
    output logic                      ValidOut_SO,
    output logic [LABEL_WIDTH-1:0]    LabelOut_A_DO,
    output logic [LABEL_WIDTH-1:0]    LabelOut_V_DO,
    output logic [VOTE_WIDTH-1:0]     VotesOut_A_DO,
    output logic [VOTE_WIDTH-1:0]     VotesOut_V_DO
);

    localparam logic [DISTANCE_WIDTH-1:0] THRESHOLD  = DISTANCE_WIDTH'(DIST_THRESHOLD);
    localparam logic [LABEL_WIDTH-1:0]    LAST_CLASS = LABEL_WIDTH'(CLASSES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VOTE   = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    typedef logic [WINDOW-1:0][LABEL_WIDTH-1:0] labelWin_t;
    typedef logic [WINDOW-1:0]                  voteWin_t;

    state_t                  state;
    logic                    accept;
    logic                    sampleVoteA;
    logic                    sampleVoteV;

    labelWin_t               winLabelA;
    labelWin_t               winLabelV;
    voteWin_t                winVoteA;
    voteWin_t                winVoteV;

    // The class counter only ever holds 0..CLASSES-1, so window labels at or
    // above CLASSES can never compare equal to it and never collect votes.
    logic [LABEL_WIDTH-1:0]  classCnt;

    logic [VOTE_WIDTH-1:0]   bestCountA;
    logic [VOTE_WIDTH-1:0]   bestCountV;
    logic [LABEL_WIDTH-1:0]  bestLabelA;
    logic [LABEL_WIDTH-1:0]  bestLabelV;

    logic [VOTE_WIDTH-1:0]   countA;
    logic [VOTE_WIDTH-1:0]   countV;
    logic [VOTE_WIDTH-1:0]   candCountA;
    logic [VOTE_WIDTH-1:0]   candCountV;
    logic [LABEL_WIDTH-1:0]  candLabelA;
    logic [LABEL_WIDTH-1:0]  candLabelV;

    // Number of voting slots in one window whose label equals the class under test.
    function automatic logic [VOTE_WIDTH-1:0] countVotes(
        input labelWin_t              labels,
        input voteWin_t               votes,
        input logic [LABEL_WIDTH-1:0] cls
    );
        logic [VOTE_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < WINDOW; i++) begin
            if (votes[i] && (labels[i] == cls)) begin
                n = n + VOTE_WIDTH'(1);
            end
        end
        return n;
    endfunction

    assign accept      = (state == ST_IDLE) && ValidIn_SI;
    assign sampleVoteA = (DistanceIn_A_DI <= THRESHOLD);
    assign sampleVoteV = (DistanceIn_V_DI <= THRESHOLD);

    // Shift both windows on accept; clear wipes every slot, and when it lands
    // on an accept the new sample survives alone in slot 0.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            winLabelA <= '0;
            winLabelV <= '0;
            winVoteA  <= '0;
            winVoteV  <= '0;
        end else if (accept) begin
            winLabelA[0] <= LabelIn_A_DI;
            winLabelV[0] <= LabelIn_V_DI;
            winVoteA[0]  <= sampleVoteA;
            winVoteV[0]  <= sampleVoteV;
            for (int i = 1; i < WINDOW; i++) begin
                winLabelA[i] <= Clear_SI ? '0   : winLabelA[i-1];
                winLabelV[i] <= Clear_SI ? '0   : winLabelV[i-1];
                winVoteA[i]  <= Clear_SI ? 1'b0 : winVoteA[i-1];
                winVoteV[i]  <= Clear_SI ? 1'b0 : winVoteV[i-1];
            end
        end else if (Clear_SI) begin
            winLabelA <= '0;
            winLabelV <= '0;
            winVoteA  <= '0;
            winVoteV  <= '0;
        end
    end

    // Votes for the current class and the running best; strict compare keeps ties on the lower class.
    always_comb begin
        countA     = countVotes(winLabelA, winVoteA, classCnt);
        countV     = countVotes(winLabelV, winVoteV, classCnt);
        candCountA = bestCountA;
        candLabelA = bestLabelA;
        candCountV = bestCountV;
        candLabelV = bestLabelV;
        if (countA > bestCountA) begin
            candCountA = countA;
            candLabelA = classCnt;
        end
        if (countV > bestCountV) begin
            candCountV = countV;
            candLabelV = classCnt;
        end
    end

    // Control FSM: accept in IDLE, scan one class per cycle in VOTE, hold the result in OUTPUT.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state         <= ST_IDLE;
            classCnt      <= '0;
            bestCountA    <= '0;
            bestCountV    <= '0;
            bestLabelA    <= '0;
            bestLabelV    <= '0;
            LabelOut_A_DO <= '0;
            LabelOut_V_DO <= '0;
            VotesOut_A_DO <= '0;
            VotesOut_V_DO <= '0;
            ValidOut_SO   <= 1'b0;
            ReadyOut_SO   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ValidIn_SI) begin
                        state       <= ST_VOTE;
                        ReadyOut_SO <= 1'b0;
                        classCnt    <= '0;
                        bestCountA  <= '0;
                        bestCountV  <= '0;
                        // Seeding with the held label makes an all-silent window keep its previous answer.
                        bestLabelA  <= LabelOut_A_DO;
                        bestLabelV  <= LabelOut_V_DO;
                    end
                end
                ST_VOTE: begin
                    bestCountA <= candCountA;
                    bestCountV <= candCountV;
                    bestLabelA <= candLabelA;
                    bestLabelV <= candLabelV;
                    classCnt   <= classCnt + LABEL_WIDTH'(1);
                    if (classCnt == LAST_CLASS) begin
                        LabelOut_A_DO <= candLabelA;
                        LabelOut_V_DO <= candLabelV;
                        VotesOut_A_DO <= candCountA;
                        VotesOut_V_DO <= candCountV;
                        ValidOut_SO   <= 1'b1;
                        state         <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (ReadyIn_SI) begin
                        state       <= ST_IDLE;
                        ValidOut_SO <= 1'b0;
                        ReadyOut_SO <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    ValidOut_SO <= 1'b0;
                    ReadyOut_SO <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_label_vote_filter.sv
// tb/tb_label_vote_filter.sv - directed self-checking bench for label_vote_filter
module tb_label_vote_filter;

    localparam int LW = 1;
    localparam int DW = 11;
    localparam int VW = 3;

    logic          Clk_CI = 1'b0;
    logic          Reset_RI;
    logic          ValidIn_SI;
    logic          ReadyOut_SO;
    logic [LW-1:0] LabelIn_A_DI;
    logic [LW-1:0] LabelIn_V_DI;
    logic [DW-1:0] DistanceIn_A_DI;
    logic [DW-1:0] DistanceIn_V_DI;
    logic          Clear_SI;
    logic          ReadyIn_SI;
    logic          ValidOut_SO;
    logic [LW-1:0] LabelOut_A_DO;
    logic [LW-1:0] LabelOut_V_DO;
    logic [VW-1:0] VotesOut_A_DO;
    logic [VW-1:0] VotesOut_V_DO;

    int total = 0;
    int bad   = 0;

    label_vote_filter dut (
        .Clk_CI          (Clk_CI),
        .Reset_RI        (Reset_RI),
        .ValidIn_SI      (ValidIn_SI),
        .ReadyOut_SO     (ReadyOut_SO),
        .LabelIn_A_DI    (LabelIn_A_DI),
        .LabelIn_V_DI    (LabelIn_V_DI),
        .DistanceIn_A_DI (DistanceIn_A_DI),
        .DistanceIn_V_DI (DistanceIn_V_DI),
        .Clear_SI        (Clear_SI),
        .ReadyIn_SI      (ReadyIn_SI),
        .ValidOut_SO     (ValidOut_SO),
        .LabelOut_A_DO   (LabelOut_A_DO),
        .LabelOut_V_DO   (LabelOut_V_DO),
        .VotesOut_A_DO   (VotesOut_A_DO),
        .VotesOut_V_DO   (VotesOut_V_DO)
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp)) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk_CI);
        #1;
    endtask

    // Present one sample in IDLE, then wait (bounded) until the result is valid.
    task automatic feed(input int la, input int da, input int lv, input int dv,
                        input logic clr, output int lat);
        LabelIn_A_DI    = LW'(la);
        DistanceIn_A_DI = DW'(da);
        LabelIn_V_DI    = LW'(lv);
        DistanceIn_V_DI = DW'(dv);
        Clear_SI        = clr;
        ValidIn_SI      = 1'b1;
        cyc();
        ValidIn_SI = 1'b0;
        Clear_SI   = 1'b0;
        lat        = 1;
        while (ValidOut_SO !== 1'b1 && lat < 20) begin
            cyc();
            lat++;
        end
    endtask

    task automatic step(input string tag, input int la, input int da, input int lv, input int dv,
                        input logic clr, input int eLA, input int eVA, input int eLV, input int eVV);
        int lat;
        feed(la, da, lv, dv, clr, lat);
        check({tag, "/valid"}, 32'(ValidOut_SO), 1);
        check({tag, "/labelA"}, 32'(LabelOut_A_DO), eLA);
        check({tag, "/votesA"}, 32'(VotesOut_A_DO), eVA);
        check({tag, "/labelV"}, 32'(LabelOut_V_DO), eLV);
        check({tag, "/votesV"}, 32'(VotesOut_V_DO), eVV);
        cyc();
    endtask

    task automatic clearPulse();
        Clear_SI = 1'b1;
        cyc();
        Clear_SI = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int seen;
        int seqA[5];
        int eLA[5];
        int eVA[5];
        int eVV[5];

        Reset_RI        = 1'b1;
        ValidIn_SI      = 1'b0;
        LabelIn_A_DI    = '0;
        LabelIn_V_DI    = '0;
        DistanceIn_A_DI = '0;
        DistanceIn_V_DI = '0;
        Clear_SI        = 1'b0;
        ReadyIn_SI      = 1'b1;
        cyc();
        cyc();
        check("reset/ready", 32'(ReadyOut_SO), 1);
        check("reset/valid", 32'(ValidOut_SO), 0);
        check("reset/labelA", 32'(LabelOut_A_DO), 0);
        check("reset/votesA", 32'(VotesOut_A_DO), 0);
        check("reset/labelV", 32'(LabelOut_V_DO), 0);
        check("reset/votesV", 32'(VotesOut_V_DO), 0);
        Reset_RI = 1'b0;
        cyc();

        // First sample: latency, values, handshake signals.
        feed(1, 100, 0, 100, 1'b0, lat);
        check("first/latency", 32'(lat), 3);
        check("first/labelA", 32'(LabelOut_A_DO), 1);
        check("first/votesA", 32'(VotesOut_A_DO), 1);
        check("first/labelV", 32'(LabelOut_V_DO), 0);
        check("first/votesV", 32'(VotesOut_V_DO), 1);
        check("first/readyBusy", 32'(ReadyOut_SO), 0);
        cyc();
        check("first/readyIdle", 32'(ReadyOut_SO), 1);
        check("first/validIdle", 32'(ValidOut_SO), 0);

        // A labels 1,0,1,0,0 on top of the first 1; the fifth evicts it.
        seqA = '{1, 0, 1, 0, 0};
        eLA  = '{1, 1, 1, 1, 0};
        eVA  = '{2, 2, 3, 3, 3};
        eVV  = '{2, 3, 4, 5, 5};
        for (int i = 0; i < 5; i++) begin
            step($sformatf("fill%0d", i), seqA[i], 100, 0, 100, 1'b0, eLA[i], eVA[i], 0, eVV[i]);
        end
        step("evict", 1, 100, 0, 100, 1'b0, 0, 3, 0, 5);

        // Non-voting A=1 samples at d=700 push out the voters one by one.
        eLA = '{0, 0, 0, 1, 1};
        eVA = '{2, 2, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            step($sformatf("nv700_%0d", i), 1, 700, 0, 100, 1'b0, eLA[i], eVA[i], 0, 5);
        end
        step("d600", 1, 600, 0, 100, 1'b0, 1, 1, 0, 5);

        // d=601 never votes: the single 600 voter holds label 1 until evicted.
        eVA = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            step($sformatf("nv601_%0d", i), 0, 601, 0, 100, 1'b0, 1, eVA[i], 0, 5);
        end

        // Clear alone leaves the outputs untouched.
        clearPulse();
        check("clear/valid", 32'(ValidOut_SO), 0);
        check("clear/labelA", 32'(LabelOut_A_DO), 1);
        check("clear/votesV", 32'(VotesOut_V_DO), 5);

        // Tie between 0 and 1 resolves to 0 even with label 1 held.
        step("tie1", 1, 100, 1, 100, 1'b0, 1, 1, 1, 1);
        step("tie2", 0, 100, 1, 700, 1'b0, 0, 1, 1, 1);

        // Back-pressure: result held, ValidIn pulses ignored.
        ReadyIn_SI = 1'b0;
        feed(1, 100, 0, 100, 1'b0, lat);
        check("bp/labelA", 32'(LabelOut_A_DO), 1);
        check("bp/votesA", 32'(VotesOut_A_DO), 2);
        check("bp/labelV", 32'(LabelOut_V_DO), 0);
        check("bp/votesV", 32'(VotesOut_V_DO), 1);
        LabelIn_A_DI    = '0;
        LabelIn_V_DI    = '0;
        DistanceIn_A_DI = '0;
        DistanceIn_V_DI = '0;
        for (int k = 0; k < 10; k++) begin
            ValidIn_SI = 1'b1;
            cyc();
            check($sformatf("bp%0d/valid", k), 32'(ValidOut_SO), 1);
            check($sformatf("bp%0d/ready", k), 32'(ReadyOut_SO), 0);
            check($sformatf("bp%0d/labelA", k), 32'(LabelOut_A_DO), 1);
            check($sformatf("bp%0d/votesA", k), 32'(VotesOut_A_DO), 2);
        end
        ValidIn_SI = 1'b0;
        ReadyIn_SI = 1'b1;
        cyc();
        check("bp/releaseValid", 32'(ValidOut_SO), 0);
        check("bp/releaseReady", 32'(ReadyOut_SO), 1);
        step("bpAfter", 0, 100, 1, 100, 1'b0, 0, 2, 1, 2);

        // Four 0s, then clear coincident with accept of A=1/V=1.
        clearPulse();
        for (int k = 0; k < 4; k++) begin
            step($sformatf("zeros%0d", k), 0, 100, 0, 100, 1'b0, 0, k + 1, 0, k + 1);
        end
        step("clrAccept", 1, 100, 1, 100, 1'b1, 1, 1, 1, 1);

        // Reset while in VOTE aborts the result.
        LabelIn_A_DI    = 1'b0;
        LabelIn_V_DI    = 1'b0;
        DistanceIn_A_DI = DW'(100);
        DistanceIn_V_DI = DW'(100);
        ValidIn_SI      = 1'b1;
        cyc();
        ValidIn_SI = 1'b0;
        Reset_RI   = 1'b1;
        cyc();
        Reset_RI = 1'b0;
        check("rst/valid", 32'(ValidOut_SO), 0);
        check("rst/ready", 32'(ReadyOut_SO), 1);
        check("rst/labelA", 32'(LabelOut_A_DO), 0);
        check("rst/votesA", 32'(VotesOut_A_DO), 0);
        check("rst/labelV", 32'(LabelOut_V_DO), 0);
        check("rst/votesV", 32'(VotesOut_V_DO), 0);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (ValidOut_SO !== 1'b0) seen = 1;
        end
        check("rst/noOutput", 32'(seen), 0);
        step("postReset", 1, 100, 0, 700, 1'b0, 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
